// File: rtl/display_scan.sv
// Multiplexed 7-segment scan driver for N digits.
// Frame = N slots of SLOT_CYC cycles; inputs are snapshotted once per frame so a
// frame never mixes old and new values. Each slot opens with DEAD_CYC blank
// cycles (anti-ghosting), then lights under a PWM brightness mask.
// Optional feature: define DISPLAY_SCAN_BLINK_EN to add the per-digit `blink`
// input, the BLINK_SHIFT parameter and a frame counter that gates blinking digits.
module display_scan #(
  parameter int unsigned N           = 8,
  parameter int unsigned SLOT_CYC    = 8192,
  parameter int unsigned DEAD_CYC    = 64,
  parameter int unsigned BRIGHT_W    = 4,
  parameter int unsigned HEX         = 0,
  parameter int unsigned LZ_BLANK    = 0,
  parameter int unsigned SEG_ACT_LOW = 1,
  parameter int unsigned DIG_ACT_LOW = 1
`ifdef DISPLAY_SCAN_BLINK_EN
  ,
  parameter int unsigned BLINK_SHIFT = 5
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        vld,
  input  logic [4*N-1:0]      digits,
  input  logic [N-1:0]        dots,
  input  logic [BRIGHT_W-1:0] bright,
`ifdef DISPLAY_SCAN_BLINK_EN
  input  logic [N-1:0]        blink,
`endif
  output logic [N-1:0]        led_ptr_out,
  output logic [7:0]          led_out,
  output logic                frame_start
);

  localparam int unsigned SC_W  = $clog2(SLOT_CYC);
  localparam int unsigned PTR_W = $clog2(N);

  localparam logic [N-1:0] DigIdle = (DIG_ACT_LOW != 0) ? '1 : '0;
  localparam logic [7:0]   SegIdle = (SEG_ACT_LOW != 0) ? '1 : '0;

  logic [SC_W-1:0]       sc_q, sc_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  slot_end, frame_end;

  logic [N-1:0]          vld_s_q, dots_s_q;
  logic [N-1:0][3:0]     digits_s_q;
  logic [BRIGHT_W-1:0]   bright_s_q;

  logic [N-1:0]          led_ptr_q, led_ptr_d;
  logic [7:0]            led_q, led_d;
  logic                  frame_start_q, frame_start_d;

  logic [N-1:0]          lz_blank;
  logic                  lz_run;
  logic                  lit;
  logic [6:0]            seg_on;
  logic                  dp_on;
  logic [N-1:0]          dig_act;

`ifdef DISPLAY_SCAN_BLINK_EN
  logic [N-1:0]           blink_s_q;
  logic [BLINK_SHIFT-1:0] fc_q;
`endif

  // gfedcba pattern; without HEX, 10..15 render as 'E'
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b0111111;
      4'h1:    s = 7'b0000110;
      4'h2:    s = 7'b1011011;
      4'h3:    s = 7'b1001111;
      4'h4:    s = 7'b1100110;
      4'h5:    s = 7'b1101101;
      4'h6:    s = 7'b1111101;
      4'h7:    s = 7'b0000111;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1101111;
      4'ha:    s = 7'b1110111;
      4'hb:    s = 7'b1111100;
      4'hc:    s = 7'b0111001;
      4'hd:    s = 7'b1011110;
      4'he:    s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    if (HEX == 0 && v > 4'd9) s = 7'b1111001;
    return s;
  endfunction

  // Slot/pointer counters and the frame-boundary flag used by the snapshot
  always_comb begin
    slot_end  = (sc_q == SC_W'(SLOT_CYC - 1));
    frame_end = slot_end && (ptr_q == PTR_W'(N - 1));
    sc_d      = sc_q + 1'b1;
    ptr_d     = ptr_q;
    if (slot_end) begin
      sc_d  = '0;
      ptr_d = frame_end ? '0 : ptr_q + 1'b1;
    end
    // High exactly in the cycle whose closing edge takes the snapshot
    frame_start_d = (sc_d == SC_W'(SLOT_CYC - 1)) && (ptr_d == PTR_W'(N - 1));
  end

  // Leading-zero mask: a digit blanks while it and all digits above are zero/invalid
  always_comb begin
    lz_blank = '0;
    lz_run   = 1'b1;
    if (LZ_BLANK != 0) begin
      for (int i = N - 1; i >= 1; i--) begin
        lz_run      = lz_run & (~vld_s_q[i] | (digits_s_q[i] == 4'd0));
        lz_blank[i] = lz_run;
      end
    end
  end

  // Lit decision and pattern for the current slot, registered next edge
  always_comb begin
    lit = (sc_q >= SC_W'(DEAD_CYC)) &&
          ((&bright_s_q) || (sc_q[BRIGHT_W-1:0] < bright_s_q));
    seg_on = '0;
    if (vld_s_q[ptr_q] && !lz_blank[ptr_q]) seg_on = seg_decode(digits_s_q[ptr_q]);
    dp_on = vld_s_q[ptr_q] & dots_s_q[ptr_q];
`ifdef DISPLAY_SCAN_BLINK_EN
    if (blink_s_q[ptr_q] && fc_q[BLINK_SHIFT-1]) begin
      seg_on = '0;
      dp_on  = 1'b0;
    end
`endif
    dig_act        = '0;
    dig_act[ptr_q] = 1'b1;
    if (!lit) begin
      dig_act = '0;
      seg_on  = '0;
      dp_on   = 1'b0;
    end
    led_ptr_d = (DIG_ACT_LOW != 0) ? ~dig_act : dig_act;
    led_d     = (SEG_ACT_LOW != 0) ? ~{dp_on, seg_on} : {dp_on, seg_on};
  end

  // State, snapshot and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sc_q          <= '0;
      ptr_q         <= '0;
      vld_s_q       <= '0;
      dots_s_q      <= '0;
      digits_s_q    <= '0;
      bright_s_q    <= '0;
      led_ptr_q     <= DigIdle;
      led_q         <= SegIdle;
      frame_start_q <= 1'b0;
`ifdef DISPLAY_SCAN_BLINK_EN
      blink_s_q     <= '0;
      fc_q          <= '0;
`endif
    end else begin
      sc_q          <= sc_d;
      ptr_q         <= ptr_d;
      led_ptr_q     <= led_ptr_d;
      led_q         <= led_d;
      frame_start_q <= frame_start_d;
      if (frame_end) begin
        vld_s_q    <= vld;
        dots_s_q   <= dots;
        digits_s_q <= digits;
        bright_s_q <= bright;
`ifdef DISPLAY_SCAN_BLINK_EN
        blink_s_q  <= blink;
        fc_q       <= fc_q + 1'b1;
`endif
      end
    end
  end

  assign led_ptr_out = led_ptr_q;
  assign led_out     = led_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan.sv
// Randomized bench for display_scan: two instances (decimal/active-low and
// hex + leading-zero blanking/active-high) against a frame-arithmetic model.
module tb_display_scan;

  localparam int N     = 4;
  localparam int SLOT  = 16;
  localparam int DEAD  = 2;
  localparam int BW    = 2;
  localparam int FRAME = N * SLOT;
  localparam int NCYC  = 16 * FRAME;
  localparam int RST_AT = 8 * FRAME + 37;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    vld = '0;
  logic [N-1:0]    dots = '0;
  logic [4*N-1:0]  digits = '0;
  logic [BW-1:0]   bright = '0;

  logic [N-1:0]    ptr_a, ptr_b;
  logic [7:0]      led_a, led_b;
  logic            fs_a, fs_b;

  int checks = 0;
  int errors = 0;

  // Model snapshot of the inputs in force for the frame being shown
  logic [N-1:0]    s_vld, s_dots;
  logic [4*N-1:0]  s_dig;
  logic [BW-1:0]   s_bright;
  logic [6:0]      seg_tab [16];

  display_scan #(
    .N(N), .SLOT_CYC(SLOT), .DEAD_CYC(DEAD), .BRIGHT_W(BW), .HEX(0), .LZ_BLANK(0),
    .SEG_ACT_LOW(1), .DIG_ACT_LOW(1)
  ) dut_a (
    .clk(clk), .rst(rst), .vld(vld), .digits(digits), .dots(dots), .bright(bright),
    .led_ptr_out(ptr_a), .led_out(led_a), .frame_start(fs_a)
  );

  display_scan #(
    .N(N), .SLOT_CYC(SLOT), .DEAD_CYC(DEAD), .BRIGHT_W(BW), .HEX(1), .LZ_BLANK(1),
    .SEG_ACT_LOW(0), .DIG_ACT_LOW(0)
  ) dut_b (
    .clk(clk), .rst(rst), .vld(vld), .digits(digits), .dots(dots), .bright(bright),
    .led_ptr_out(ptr_b), .led_out(led_b), .frame_start(fs_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Active-high {digit select[3:0], dp, gfedcba} for model cycle t
  function automatic logic [11:0] model(input int t, input bit hex, input bit lz);
    int p, ptr, sc;
    logic [3:0] v;
    logic [6:0] seg;
    logic dp;
    bit blank;
    p   = t % FRAME;
    ptr = p / SLOT;
    sc  = p % SLOT;
    if (sc < DEAD) return 12'h0;
    if (s_bright != {BW{1'b1}} && (sc % (1 << BW)) >= int'(s_bright)) return 12'h0;
    v   = s_dig[ptr*4 +: 4];
    seg = (v > 4'd9 && !hex) ? seg_tab[14] : seg_tab[v];
    if (!s_vld[ptr]) seg = '0;
    blank = lz && (ptr > 0);
    for (int j = ptr; j < N; j++)
      if (s_vld[j] && s_dig[j*4 +: 4] != 4'd0) blank = 0;
    if (blank) seg = '0;
    dp = s_vld[ptr] & s_dots[ptr];
    return {4'(1 << ptr), dp, seg};
  endfunction

  initial begin
    logic [11:0] exp_a, exp_b;
    logic [3:0]  want_dig_a;
    logic [7:0]  want_led_a;
    int t, fr;

    seg_tab = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110, 7'b1101101,
                7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
    s_vld = '0; s_dots = '0; s_dig = '0; s_bright = '0;

    // Reset held for three edges: everything inactive
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("rst_dig_a", ptr_a, 4'hf);
      check_eq("rst_led_a", led_a, 8'hff);
      check_eq("rst_fs_a", fs_a, 1'b0);
      check_eq("rst_dig_b", ptr_b, 4'h0);
      check_eq("rst_led_b", led_b, 8'h00);
    end
    rst = 1'b0;

    exp_a = '0;
    exp_b = '0;
    t = 0;
    for (int g = 0; g < NCYC; g++) begin
      // Compare this cycle against the expectation derived last cycle
      want_dig_a = ~exp_a[11:8];
      want_led_a = ~exp_a[7:0];
      check_eq("dig_a", ptr_a, want_dig_a);
      check_eq("led_a", led_a, want_led_a);
      check_eq("fs_a", fs_a, (t % FRAME) == FRAME - 1);
      check_eq("dig_b", ptr_b, exp_b[11:8]);
      check_eq("led_b", led_b, exp_b[7:0]);
      check_eq("fs_b", fs_b, (t % FRAME) == FRAME - 1);
      check_eq("onehot_a", $countones(~ptr_a) <= 1, 1'b1);
      check_eq("onehot_b", $countones(ptr_b) <= 1, 1'b1);

      // Stimulus: directed frames first, then random; digits also move mid-frame
      fr = g / FRAME;
      if (g % FRAME == 0) begin
        case (fr)
          0: begin digits = 16'h1234; vld = 4'hf; dots = 4'b0001; bright = 2'd3; end
          1: begin bright = 2'd1; end
          2: begin bright = 2'd0; end
          3: begin digits = 16'h0b5b; vld = 4'b1110; dots = 4'b0101; bright = 2'd3; end
          4: begin digits = 16'h0050; vld = 4'hf; dots = 4'b1000; bright = 2'd3; end
          5: begin bright = 2'd2; end
          default: begin
            digits = 16'($urandom);
            vld    = 4'($urandom);
            dots   = 4'($urandom);
            bright = 2'($urandom_range(0, 3));
          end
        endcase
      end
      if (g % FRAME == 20 && fr >= 5) digits = 16'($urandom);
      rst = (g == RST_AT);

      // Advance the model by one cycle
      if (rst) begin
        exp_a = '0; exp_b = '0;
        s_vld = '0; s_dots = '0; s_dig = '0; s_bright = '0;
        t = 0;
      end else begin
        exp_a = model(t, 1'b0, 1'b0);
        exp_b = model(t, 1'b1, 1'b1);
        if (t % FRAME == FRAME - 1) begin
          s_vld = vld; s_dots = dots; s_dig = digits; s_bright = bright;
        end
        t++;
      end

      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
